inst_mem_responder: RTL and testbench
=====================================

# inst_mem_responder

Instruction-memory responder for the fetch stage. It accepts word fetch requests addressed by the fetch PC, inserts a programmable number of wait states, and returns the instruction with a one-cycle valid strobe. While a fetch is outstanding it raises `busy`, which is ORed into the fetch stage's `freeze`. A branch redirect (`flush`) aborts the outstanding fetch, and a load port lets the bench or boot loader fill the array.

## Interface
- `DEPTH`, 64, number of 32-bit instruction words.
- `WAIT_CYCLES`, 2, wait states per fetch; legal range 0..15.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: fetch request from the fetch stage.
- `req_addr` in 32: byte address (PC).
- `flush` in 1: branch taken; aborts the in-flight fetch.
- `resp_valid` out 1: one-cycle strobe, instruction available.
- `resp_inst` out 32: fetched instruction.
- `err` out 1: qualifies `resp_valid`; the address was misaligned or out of range.
- `busy` out 1: fetch outstanding; the fetch stage must freeze.
- `load_en` in 1: synchronous write strobe.
- `load_addr` in $clog2(DEPTH): word index for the write.
- `load_data` in 32: write data.

## Operation
- **States:**
  - IDLE: no fetch outstanding.
  - WAIT: counting wait states.
  - RESP: `resp_valid`=1.
- **Accept condition:** `req_valid`=1 while in IDLE or RESP, and `flush`=0.
- **IDLE transitions:**
  - On accept, latch `req_addr`.
  - If `WAIT_CYCLES`=0, go to RESP.
  - Otherwise go to WAIT with the counter loaded to `WAIT_CYCLES`-1.
- **WAIT transitions:**
  - Decrement the counter each cycle.
  - When the counter is 0, go to RESP.
- **RESP transitions:**
  - On accept, start a new fetch exactly as from IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- **Data capture:** `resp_inst` and `err` are registered on the edge that enters RESP.
- **Address checks:**
  - Word index = latched address[31:2].
  - If address[1:0]≠0 or index≥DEPTH: `err`=1 and `resp_inst`=0.
  - Otherwise: `err`=0 and `resp_inst`=mem[index].
- **Output hold:** `resp_inst` and `err` hold their values until the next response. They are meaningful only while `resp_valid`=1.
- **`busy` (combinational):** (IDLE ∧ `req_valid` ∧ ¬`flush`) ∨ WAIT ∨ (RESP ∧ `req_valid` ∧ ¬`flush`). It is low in the RESP cycle itself unless a new request is accepted in that cycle.
- **Flush:**
  - `flush`=1 in WAIT or RESP returns the block to IDLE.
  - `resp_valid` is forced to 0 in that cycle.
  - No request is accepted in that cycle, and `busy`=0.
  - The redirected PC arrives as a fresh request the following cycle.
- **Load port:**
  - `load_en` writes mem[`load_addr`] on the clock edge and is allowed in any state.
  - When a load and a capture hit the same word in the same cycle, the capture returns the old data (read-before-write).
- **Reset:**
  - `rst` forces IDLE, counter=0, `resp_valid`=0, `resp_inst`=0, `err`=0; `busy`=0 follows from IDLE.
  - Reset in mid-fetch drops the fetch; no response is produced.
  - Memory contents are not reset.

## Timing
- Request accepted at edge T:
  - `busy`=1 during cycles T..T+`WAIT_CYCLES`.
  - `resp_valid`=1 in cycle T+`WAIT_CYCLES`+1.
  - Latency is `WAIT_CYCLES`+1.
- Throughput:
  - One response per `WAIT_CYCLES`+1 cycles with back-to-back requests.
  - With `WAIT_CYCLES`=0, one response per cycle after the first.
- `resp_valid` is never high for two cycles for the same request.
- Each response corresponds to exactly one accepted, unflushed request.
- `flush` has priority over `req_valid` and over response delivery.

## Structure
- Shared package `cpu_defs`:
  - `INST_W`=32.
  - NOP encoding 32'hE1A00000, used by the decode stage on `err`.
  - Responder state encoding (IDLE/WAIT/RESP).
- Sub-module `inst_mem_array`: DEPTH×32 storage with synchronous write and combinational read. Capture and error logic stay in the parent.

## Test plan
- **Wait-state latency:** `WAIT_CYCLES`=2, mem[0]=32'hE3A00014; `req_valid`=1, `req_addr`=0 accepted at T → `busy` high T..T+2; `resp_valid`=1 at T+3 with `resp_inst`=32'hE3A00014, `err`=0.
- **Back-to-back, zero wait:** `WAIT_CYCLES`=0, mem[0..2]=A,B,C; requests at 0, 4, 8 on consecutive accepts → `resp_valid` high on 3 consecutive cycles returning A, B, C.
- **Flush in WAIT:** `WAIT_CYCLES`=3, `flush` pulsed in the second WAIT cycle → no `resp_valid` for that request; IDLE next; a request to 0x10 returns mem[4] 4 cycles after accept.
- **Address errors:** request 0x6, then DEPTH*4 → each gets `resp_valid`=1, `err`=1, `resp_inst`=0.
- **Reset in WAIT:** `rst` asserted during WAIT → `resp_valid`/`busy`/`resp_inst`=0 immediately; after release, a request to 0 returns the preloaded mem[0] unchanged.
- **Load/capture collision:** `load_en` to word 1 (data D2, old D1) on the edge that captures word 1 → response D1; the next fetch of 4 → D2.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: instruction width, NOP encoding, fetch responder
// state encoding and the fetch address check used by the responder.
package cpu_defs;

    localparam int INST_W = 32;

    // The decode stage substitutes this when a fetch comes back with err set.
    localparam logic [INST_W-1:0] NOP_INST = 32'hE1A00000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_e;

    // A fetch address is bad if it is not word aligned or if its word index
    // lies beyond the end of the instruction array.
    function automatic logic addr_fault(input logic [31:0] addr,
                                        input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: DEPTH x INST_W words, synchronous write port for the
// loader and an asynchronous read port for the responder's capture logic.
module inst_mem_array
    import cpu_defs::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [INST_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [INST_W-1:0] rdata_o
);

    logic [INST_W-1:0] mem_q [DEPTH];

    // Loader write; a read of the same word in the same cycle sees old data.
    // NOTE: the array has no reset -- clearing it would cost a mux per bit
    // and program contents are always loaded before fetching begins.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder for the fetch stage. Accepts word fetches,
// inserts WAIT_CYCLES wait states (0..15), then presents the instruction for
// one cycle with resp_valid. flush aborts any in-flight fetch.
module inst_mem_responder
    import cpu_defs::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [31:0]              req_addr,
    input  logic                     flush,
    output logic                     resp_valid,
    output logic [INST_W-1:0]        resp_inst,
    output logic                     err,
    output logic                     busy,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [INST_W-1:0]        load_data
);

    localparam int AW = $clog2(DEPTH);

    // Counter value loaded on accept; it counts down to zero in WAIT.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    resp_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              err_q, err_d;

    logic              accept;
    logic              capture;
    logic [31:0]       capture_addr;
    logic              capture_fault;
    logic [AW-1:0]     rd_index;
    logic [INST_W-1:0] rd_data;

    // A new fetch can start when nothing is waiting, and flush always wins.
    assign accept = req_valid && !flush &&
                    ((state_q == ST_IDLE) || (state_q == ST_RESP));

    // With zero wait states the capture happens on the accept edge, before
    // the address has been latched, so the live request address is used.
    assign capture_addr  = (state_q == ST_WAIT) ? addr_q : req_addr;
    assign capture_fault = addr_fault(capture_addr, DEPTH);
    assign rd_index      = capture_addr[AW+1:2];

    inst_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (load_en),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (rd_index),
        .rdata_o (rd_data)
    );

    // Next-state, counter and capture logic.
    // NOTE: every variable gets a default first and only blocking '=' is used
    // here, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        err_d   = err_q;
        capture = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    addr_d = req_addr;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        capture = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else begin
                    // Covers the normal end of RESP and a flush in RESP.
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (capture) begin
            err_d  = capture_fault;
            inst_d = capture_fault ? '0 : rd_data;
        end
    end

    // State and response registers; reset drops any fetch in progress.
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid = (state_q == ST_RESP) && !flush;
    assign busy       = accept || ((state_q == ST_WAIT) && !flush);
    assign resp_inst  = inst_q;
    assign err        = err_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Self-checking bench for inst_mem_responder. Three instances (0, 2 and 3
// wait states) share every input; each section checks the instance it targets.
module tb_inst_mem_responder;
    import cpu_defs::*;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [31:0] D2 = 32'hE3A02002;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              req_valid = 1'b0;
    logic [31:0]       req_addr  = 32'd0;
    logic              flush     = 1'b0;
    logic              load_en   = 1'b0;
    logic [AW-1:0]     load_addr = '0;
    logic [31:0]       load_data = 32'd0;

    logic              w0_valid, w0_err, w0_busy;
    logic              w2_valid, w2_err, w2_busy;
    logic              w3_valid, w3_err, w3_busy;
    logic [INST_W-1:0] w0_inst, w2_inst, w3_inst;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_init [DEPTH];

    typedef struct {
        logic        rv;
        logic [31:0] addr;
        logic        fl;
        logic        exp_valid;
        logic        exp_busy;
        logic        chk_data;
        logic        exp_err;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    inst_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
        .resp_valid(w0_valid), .resp_inst(w0_inst), .err(w0_err), .busy(w0_busy),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    inst_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
        .resp_valid(w2_valid), .resp_inst(w2_inst), .err(w2_err), .busy(w2_busy),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    inst_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
        .resp_valid(w3_valid), .resp_inst(w3_inst), .err(w3_err), .busy(w3_busy),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are changed.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Apply request inputs for this cycle and wait for the sampling point.
    task automatic drive(input logic rv, input logic [31:0] a, input logic fl);
        req_valid = rv;
        req_addr  = a;
        flush     = fl;
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic add_vec(input logic rv, input logic [31:0] a, input logic fl,
                           input logic ev, input logic eb, input logic cd,
                           input logic ee, input logic [31:0] ei);
        vec_t v;
        v.rv = rv; v.addr = a; v.fl = fl;
        v.exp_valid = ev; v.exp_busy = eb; v.chk_data = cd;
        v.exp_err = ee; v.exp_inst = ei;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_init[i] = 32'hA5000000 | 32'(i);
        mem_init[0] = 32'hE3A00014;
        mem_init[1] = 32'hE3A01001;
        mem_init[2] = 32'hE0812002;
        mem_init[4] = 32'hE1A0F00E;

        // Preload the shared array contents while in reset.
        rst = 1'b1;
        next_cycle();
        for (int i = 0; i < DEPTH; i++) begin
            load_en   = 1'b1;
            load_addr = AW'(i);
            load_data = mem_init[i];
            next_cycle();
        end
        load_en = 1'b0;
        do_reset();

        // ---------------- Table: two wait states ----------------
        //      rv  addr    fl    valid busy  chk  err  inst
        add_vec(0, 32'd0,   0,    0,    0,    1,   0,   32'd0);         // reset values
        add_vec(1, 32'd0,   0,    0,    1,    0,   0,   32'd0);         // accept
        add_vec(0, 32'd0,   0,    0,    1,    0,   0,   32'd0);
        add_vec(0, 32'd0,   0,    0,    1,    0,   0,   32'd0);
        add_vec(0, 32'd0,   0,    1,    0,    1,   0,   32'hE3A00014);  // T+3
        add_vec(0, 32'd0,   0,    0,    0,    1,   0,   32'hE3A00014);  // hold
        add_vec(1, 32'd6,   0,    0,    1,    0,   0,   32'd0);         // misaligned
        add_vec(0, 32'd0,   0,    0,    1,    0,   0,   32'd0);
        add_vec(0, 32'd0,   0,    0,    1,    0,   0,   32'd0);
        add_vec(1, 32'd256, 0,    1,    1,    1,   1,   32'd0);         // resp + next accept
        add_vec(0, 32'd0,   0,    0,    1,    0,   0,   32'd0);
        add_vec(0, 32'd0,   0,    0,    1,    0,   0,   32'd0);
        add_vec(0, 32'd0,   0,    1,    0,    1,   1,   32'd0);         // out of range
        add_vec(1, 32'd252, 0,    0,    1,    0,   0,   32'd0);         // last word
        add_vec(0, 32'd0,   0,    0,    1,    0,   0,   32'd0);
        add_vec(0, 32'd0,   0,    0,    1,    0,   0,   32'd0);
        add_vec(0, 32'd0,   0,    1,    0,    1,   0,   32'hA500003F);
        add_vec(1, 32'd8,   0,    0,    1,    0,   0,   32'd0);
        add_vec(0, 32'd0,   0,    0,    1,    0,   0,   32'd0);
        add_vec(0, 32'd0,   0,    0,    1,    0,   0,   32'd0);
        add_vec(1, 32'd0,   1,    0,    0,    0,   0,   32'd0);         // flush in RESP
        add_vec(0, 32'd0,   0,    0,    0,    0,   0,   32'd0);         // back in IDLE
        add_vec(1, 32'd0,   1,    0,    0,    0,   0,   32'd0);         // flush in IDLE
        add_vec(0, 32'd0,   0,    0,    0,    0,   0,   32'd0);         // nothing accepted

        foreach (vecs[i]) begin
            drive(vecs[i].rv, vecs[i].addr, vecs[i].fl);
            check($sformatf("vec%0d resp_valid", i), 32'(w2_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d busy", i), 32'(w2_busy), 32'(vecs[i].exp_busy));
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d err", i), 32'(w2_err), 32'(vecs[i].exp_err));
                check($sformatf("vec%0d resp_inst", i), w2_inst, vecs[i].exp_inst);
            end
            next_cycle();
        end

        // ---------------- Zero wait states, back to back ----------------
        do_reset();
        drive(1, 32'd0, 0);
        check("w0 first busy", 32'(w0_busy), 32'd1);
        check("w0 first valid", 32'(w0_valid), 32'd0);
        next_cycle();
        drive(1, 32'd4, 0);
        check("w0 resp A valid", 32'(w0_valid), 32'd1);
        check("w0 resp A inst", w0_inst, mem_init[0]);
        check("w0 resp A busy", 32'(w0_busy), 32'd1);
        next_cycle();
        drive(1, 32'd8, 0);
        check("w0 resp B valid", 32'(w0_valid), 32'd1);
        check("w0 resp B inst", w0_inst, mem_init[1]);
        next_cycle();
        drive(0, 32'd0, 0);
        check("w0 resp C valid", 32'(w0_valid), 32'd1);
        check("w0 resp C inst", w0_inst, mem_init[2]);
        check("w0 resp C err", 32'(w0_err), 32'd0);
        check("w0 resp C busy", 32'(w0_busy), 32'd0);
        next_cycle();
        drive(0, 32'd0, 0);
        check("w0 after valid", 32'(w0_valid), 32'd0);
        next_cycle();

        // ---------------- Three wait states, flush in WAIT ----------------
        do_reset();
        drive(1, 32'd0, 0);
        check("w3 accept busy", 32'(w3_busy), 32'd1);
        next_cycle();
        drive(0, 32'd0, 0);
        check("w3 wait1 busy", 32'(w3_busy), 32'd1);
        next_cycle();
        drive(0, 32'd0, 1);
        check("w3 flush valid", 32'(w3_valid), 32'd0);
        next_cycle();
        drive(1, 32'h10, 0);
        check("w3 redirect accept busy", 32'(w3_busy), 32'd1);
        check("w3 redirect accept valid", 32'(w3_valid), 32'd0);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(0, 32'd0, 0);
            check($sformatf("w3 redirect wait%0d valid", k), 32'(w3_valid), 32'd0);
            check($sformatf("w3 redirect wait%0d busy", k), 32'(w3_busy), 32'd1);
            next_cycle();
        end
        drive(0, 32'd0, 0);
        check("w3 redirect valid", 32'(w3_valid), 32'd1);
        check("w3 redirect inst", w3_inst, mem_init[4]);
        check("w3 redirect err", 32'(w3_err), 32'd0);
        next_cycle();

        // ---------------- Reset during WAIT (two wait states) ----------------
        do_reset();
        drive(1, 32'd4, 0);
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            drive(0, 32'd0, 0);
            next_cycle();
        end
        drive(0, 32'd0, 0);
        check("rstw pre valid", 32'(w2_valid), 32'd1);
        check("rstw pre inst", w2_inst, mem_init[1]);
        next_cycle();
        drive(1, 32'd0, 0);
        next_cycle();
        drive(0, 32'd0, 0);
        check("rstw in wait busy", 32'(w2_busy), 32'd1);
        next_cycle();
        rst = 1'b1;
        drive(0, 32'd0, 0);
        check("rstw reset valid", 32'(w2_valid), 32'd0);
        check("rstw reset busy", 32'(w2_busy), 32'd0);
        check("rstw reset inst", w2_inst, 32'd0);
        check("rstw reset err", 32'(w2_err), 32'd0);
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 32'd0, 0);
            check($sformatf("rstw dropped%0d valid", k), 32'(w2_valid), 32'd0);
            next_cycle();
        end
        drive(1, 32'd0, 0);
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            drive(0, 32'd0, 0);
            next_cycle();
        end
        drive(0, 32'd0, 0);
        check("rstw refetch valid", 32'(w2_valid), 32'd1);
        check("rstw refetch inst", w2_inst, mem_init[0]);
        next_cycle();

        // ---------------- Load/capture collision (two wait states) ----------------
        do_reset();
        drive(1, 32'd4, 0);
        next_cycle();
        drive(0, 32'd0, 0);
        next_cycle();
        load_en   = 1'b1;
        load_addr = AW'(1);
        load_data = D2;
        drive(0, 32'd0, 0);
        check("coll capture-edge busy", 32'(w2_busy), 32'd1);
        next_cycle();
        load_en = 1'b0;
        drive(0, 32'd0, 0);
        check("coll old valid", 32'(w2_valid), 32'd1);
        check("coll old inst", w2_inst, mem_init[1]);
        next_cycle();
        drive(1, 32'd4, 0);
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            drive(0, 32'd0, 0);
            next_cycle();
        end
        drive(0, 32'd0, 0);
        check("coll new valid", 32'(w2_valid), 32'd1);
        check("coll new inst", w2_inst, D2);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
